// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).
// One bit is consumed per clock. A start/busy/done handshake frames each
// conversion. Values above 10^DIGITS-1 raise ovf and leave the result
// modulo 10^DIGITS in bcd.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
);

    localparam int unsigned   BW       = 4 * DIGITS;
    localparam int unsigned   CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [BW-1:0]    digits;
    logic [BW-1:0]    digits_adj;
    logic [BW-1:0]    digits_next;
    logic [CW-1:0]    cnt;
    logic             sticky;
    logic             carry_out;
    logic             load;
    logic             last;

    // Add 3 to every scratch digit >= 5, then form the shifted digits and
    // shift register. Bit 3 of the top adjusted digit falls off the end and
    // marks overflow.
    always_comb begin
        digits_adj = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digits[4*i +: 4] >= 4'd5)
                digits_adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
            else
                digits_adj[4*i +: 4] = digits[4*i +: 4];
        end
        carry_out   = digits_adj[BW-1];
        digits_next = {digits_adj[BW-2:0], shreg[WIDTH-1]};
        shreg_next  = shreg << 1;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic and the load/finish strobes for the datapath.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        last       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    load       = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == CNT_ONE) begin
                    state_next = IDLE;
                    last       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    // Datapath: capture on start, shift while busy, and publish the result
    // only on the final shift so bcd/ovf never show intermediate values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg  <= '0;
            digits <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            done   <= 1'b0;
            bcd    <= '0;
            ovf    <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                shreg  <= bin;
                digits <= '0;
                sticky <= 1'b0;
                cnt    <= CNT_LOAD;
            end else if (state == SHIFT) begin
                shreg  <= shreg_next;
                digits <= digits_next;
                sticky <= sticky | carry_out;
                cnt    <= cnt - CNT_ONE;
            end
            if (last) begin
                bcd <= digits_next;
                ovf <= sticky | carry_out;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a vector table, hand-written
// corner sequences, an exhaustive sweep and randomized conversions, all
// compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [7:0]  bin, bin2;
    logic        busy, done, ovf;
    logic [11:0] bcd;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [11:0] hold0 = '0;
    logic [11:0] hold1 = '0;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
    );

    // Expected digits: plain decimal arithmetic, truncated to nd digits.
    function automatic logic [11:0] ref_bcd(input int unsigned v, input int unsigned nd);
        logic [11:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int unsigned i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v, input int unsigned nd);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < nd; i++) p = p * 10;
        return (v >= p);
    endfunction

    // Active-high gfedcba glyphs; anything outside 0..9 has no glyph.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Start one conversion on instance `which`, wait (bounded) for done.
    // While busy, bcd must keep showing the previous result; with noise set,
    // bin and start are scrambled to prove they are ignored.
    task automatic conv(input int which, input logic [7:0] v, input logic noise,
                        output logic [11:0] res, output logic r_ovf, output int lat);
        if (which == 0) begin bin = v; start = 1'b1; end
        else begin bin2 = v; start2 = 1'b1; end
        @(posedge clk); #1;
        start  = 1'b0;
        start2 = 1'b0;
        check("busy_after_start", (which == 0) ? busy : busy2, 1);
        lat = 0;
        while (lat < 20) begin
            if ((which == 0) ? done : done2) break;
            if (which == 0) begin
                check("busy_during", busy, 1);
                check("bcd_hold", bcd, hold0);
            end else begin
                check("busy_during2", busy2, 1);
                check("bcd_hold2", bcd2, hold1[7:0]);
            end
            if (noise) begin
                if (which == 0) begin bin = 8'($urandom); start = 1'($urandom); end
                else begin bin2 = 8'($urandom); start2 = 1'($urandom); end
            end
            @(posedge clk); #1;
            lat++;
        end
        start  = 1'b0;
        start2 = 1'b0;
        check("latency", lat, 8);
        if (which == 0) begin
            check("busy_done_excl", busy, 0);
            res   = bcd;
            r_ovf = ovf;
        end else begin
            check("busy_done_excl2", busy2, 0);
            res   = {4'h0, bcd2};
            r_ovf = ovf2;
        end
    endtask

    // Convert and compare against the model; also checks the digit range
    // and that every digit decodes to a real 7-segment glyph.
    task automatic run(input int which, input logic [7:0] v, input logic noise);
        logic [11:0] res, exp;
        logic        o;
        int          lat;
        int unsigned nd;
        nd  = (which == 0) ? 3 : 2;
        conv(which, v, noise, res, o, lat);
        exp = ref_bcd(v, nd);
        check((which == 0) ? "model_bcd" : "model_bcd2", res, exp);
        check((which == 0) ? "model_ovf" : "model_ovf2", o, ref_ovf(v, nd));
        for (int unsigned i = 0; i < nd; i++) begin
            check("digit_le9", (res[4*i +: 4] <= 4'd9), 1);
            check("seg_valid", (seg7(res[4*i +: 4]) != 7'h00), 1);
        end
        if (which == 0) hold0 = exp;
        else hold1 = exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] res;
        logic        o;
        int          lat;
        int          dcount;

        vecs[0] = '{bin: 8'd0,   bcd: 12'h000, ovf: 1'b0};
        vecs[1] = '{bin: 8'd255, bcd: 12'h255, ovf: 1'b0};
        vecs[2] = '{bin: 8'd99,  bcd: 12'h099, ovf: 1'b0};
        vecs[3] = '{bin: 8'd10,  bcd: 12'h010, ovf: 1'b0};
        vecs[4] = '{bin: 8'd1,   bcd: 12'h001, ovf: 1'b0};
        vecs[5] = '{bin: 8'd9,   bcd: 12'h009, ovf: 1'b0};
        vecs[6] = '{bin: 8'd100, bcd: 12'h100, ovf: 1'b0};
        vecs[7] = '{bin: 8'd128, bcd: 12'h128, ovf: 1'b0};
        vecs[8] = '{bin: 8'd199, bcd: 12'h199, ovf: 1'b0};
        vecs[9] = '{bin: 8'd64,  bcd: 12'h064, ovf: 1'b0};

        rst = 1'b0; start = 1'b0; start2 = 1'b0; bin = '0; bin2 = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors run back to back (each start issued in the done cycle).
        for (int i = 0; i < 10; i++) begin
            conv(0, vecs[i].bin, 1'b0, res, o, lat);
            check("vec_bcd", res, vecs[i].bcd);
            check("vec_ovf", o, vecs[i].ovf);
            hold0 = vecs[i].bcd;
        end

        // Second start at cycle 3 of a conversion is ignored.
        @(posedge clk); #1;
        bin = 8'd200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < 20 && !done) begin
            if (lat == 2) begin bin = 8'd17; start = 1'b1; end
            else begin start = 1'b0; end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("ign_latency", lat, 8);
        check("ign_bcd", bcd, 12'h200);
        hold0 = 12'h200;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("ign_no_second_done", dcount, 0);
        check("ign_idle", busy, 0);

        // Asynchronous reset in cycle 4 of a conversion of 123.
        bin = 8'd123; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_bcd", bcd, 0);
        check("mid_rst_ovf", ovf, 0);
        #2 rst = 1'b0;
        hold0 = '0;
        hold1 = '0;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        check("mid_rst_no_done", dcount, 0);
        conv(0, 8'd45, 1'b0, res, o, lat);
        check("after_rst_bcd", res, 12'h045);
        hold0 = 12'h045;

        // Exhaustive sweep against the model.
        for (int v = 0; v < 256; v++) run(0, 8'(v), 1'b0);

        // Randomized conversions with random gaps and input noise while busy.
        for (int n = 0; n < 40; n++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                @(posedge clk); #1;
                check("gap_hold", bcd, hold0);
            end
            run(0, 8'($urandom), 1'b1);
        end

        // Two-digit instance: overflow and sticky-flag clearing.
        conv(1, 8'd100, 1'b0, res, o, lat);
        check("d2_100_bcd", res, 12'h000);
        check("d2_100_ovf", o, 1);
        hold1 = 12'h000;
        conv(1, 8'd99, 1'b0, res, o, lat);
        check("d2_99_bcd", res, 12'h099);
        check("d2_99_ovf", o, 0);
        hold1 = 12'h099;
        for (int n = 0; n < 30; n++) run(1, 8'($urandom), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
